// File: rtl/reg_readout.sv
// Readout transmitter: snapshots R0..R2 on start and streams 12 data bytes
// plus an XOR checksum byte over a valid/ready byte link.
module reg_readout (
    input  logic        clk,
    input  logic        res,
    input  logic        start,
    input  logic [31:0] r0in,
    input  logic [31:0] r1in,
    input  logic [31:0] r2in,
    output logic [7:0]  dout,
    output logic        dvalid,
    input  logic        dready,
    output logic [3:0]  idx,
    output logic        busy,
    output logic        done
);

    localparam int          W         = 32;
    localparam int          NBYTES    = 3 * (W / 8) + 1;
    localparam logic [3:0]  LAST_IDX  = 4'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t          state, state_n;
    logic [3*W-1:0]  shreg;
    logic [7:0]      csum;
    logic [3:0]      cnt;
    logic            accept;
    logic            last;

    assign accept = (state == SEND) && dready;
    assign last   = (cnt == LAST_IDX);

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SEND;
            SEND:    if (accept && last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Shift register is reset too: an abandoned frame must leave no residue.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            shreg <= '0;
            csum  <= '0;
            cnt   <= '0;
        end else if (state == IDLE && start) begin
            shreg <= {r2in, r1in, r0in};
            csum  <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= shreg >> 8;
            if (!last) begin
                csum <= csum ^ shreg[7:0];
            end
            cnt <= cnt + 4'd1;
        end
    end

    // Outputs decode registered state only; dready and start never reach them.
    always_comb begin
        dvalid = (state == SEND);
        busy   = (state != IDLE);
        done   = (state == DONE);
        idx    = (state == SEND) ? cnt : 4'd0;
        dout   = 8'd0;
        if (state == SEND) begin
            dout = last ? csum : shreg[7:0];
        end
    end

endmodule

// File: tb/tb_reg_readout.sv
// Self-checking bench for reg_readout: directed and randomized frames checked
// against a byte-list model built from the register values.
module tb_reg_readout;

    logic        clk = 1'b0;
    logic        res;
    logic        start;
    logic [31:0] r0in, r1in, r2in;
    logic [7:0]  dout;
    logic        dvalid;
    logic        dready;
    logic [3:0]  idx;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_readout dut (
        .clk    (clk),
        .res    (res),
        .start  (start),
        .r0in   (r0in),
        .r1in   (r1in),
        .r2in   (r2in),
        .dout   (dout),
        .dvalid (dvalid),
        .dready (dready),
        .idx    (idx),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   busy,   1'b0);
        check({tag, "_dvalid"}, dvalid, 1'b0);
        check({tag, "_done"},   done,   1'b0);
        check({tag, "_idx"},    idx,    4'd0);
        check({tag, "_dout"},   dout,   8'd0);
    endtask

    // Called just after a negedge with the DUT idle. rmode: 0 ready always,
    // 1 ready pattern 1,0,0, 2 random. noise scrambles start/registers
    // during the frame; hold keeps start high throughout (back-to-back).
    task automatic run_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input int rmode, input bit noise, input bit hold);
        logic [31:0] regs [3];
        logic [7:0]  exp_q [$];
        logic [7:0]  cs;
        int          k, cyc, stalls;
        regs = '{a, b, c};
        cs   = 8'd0;
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(regs[i / 4][8 * (i % 4) +: 8]);
            cs ^= exp_q[i];
        end
        exp_q.push_back(cs);

        r0in  = a;
        r1in  = b;
        r2in  = c;
        start = 1'b1;
        k = 0; cyc = 0; stalls = 0;
        while (k < 13 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            check("send_dvalid", dvalid, 1'b1);
            check("send_idx",    idx,    k);
            check("send_dout",   dout,   exp_q[k]);
            check("send_busy",   busy,   1'b1);
            check("send_done",   done,   1'b0);
            start = hold || (noise && $urandom_range(0, 1) == 1);
            if (noise) begin
                r0in = $urandom;
                r1in = $urandom;
                r2in = $urandom;
            end
            case (rmode)
                0:       dready = 1'b1;
                1:       dready = (cyc % 3 == 1);
                default: dready = ($urandom_range(0, 1) == 1);
            endcase
            if (dready) k++;
            else        stalls++;
        end
        check("frame_bytes", k, 13);

        @(negedge clk);
        cyc++;
        check("done_pulse",  done,   1'b1);
        check("done_dvalid", dvalid, 1'b0);
        check("done_busy",   busy,   1'b1);
        check("done_idx",    idx,    4'd0);
        start  = hold || noise;
        dready = ($urandom_range(0, 1) == 1);

        @(negedge clk);
        cyc++;
        check_idle("after_done");
        check("frame_cycles", cyc, 15 + stalls);
        start = hold;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res = 1'b0; start = 1'b0; dready = 1'b0;
        r0in = '0; r1in = '0; r2in = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        res = 1'b1;

        // Idle with dready high and no start: nothing moves.
        dready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("idle_ready");

        // Basic frame at full throughput, then with 1,0,0 backpressure.
        run_frame(32'h04030201, 32'h08070605, 32'h0C0B0A09, 0, 1'b0, 1'b0);
        run_frame(32'h04030201, 32'h08070605, 32'h0C0B0A09, 1, 1'b0, 1'b0);

        // Snapshot isolation and ignored start: inputs scrambled after capture.
        run_frame(32'hDEADBEEF, 32'h0, 32'h0, 0, 1'b1, 1'b0);
        start = 1'b0;

        // Randomized frames with random backpressure and input noise.
        repeat (4) begin
            run_frame($urandom, $urandom, $urandom, 2, 1'b1, 1'b0);
            start = 1'b0;
        end

        // Reset mid-frame at idx 7: outputs drop at once, no done.
        r0in = $urandom; r1in = $urandom; r2in = $urandom;
        start = 1'b1;
        repeat (8) begin
            @(negedge clk);
            start  = 1'b0;
            dready = 1'b1;
        end
        check("pre_reset_idx", idx, 4'd7);
        #2 res = 1'b0;
        #1 check_idle("async_reset");
        @(negedge clk);
        check("reset_no_done", done, 1'b0);
        res = 1'b1;
        run_frame($urandom, $urandom, $urandom, 0, 1'b0, 1'b0);
        start = 1'b0;

        // Back-to-back with start held high: 15-cycle period per frame.
        repeat (3) run_frame($urandom, $urandom, $urandom, 0, 1'b0, 1'b1);
        start = 1'b0;
        @(negedge clk);
        check_idle("b2b_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_readout.md
# reg_readout

Result-readout transmitter for the three-register datapath: the reader end of the register file. On a start request it snapshots the 32-bit contents of R0, R1 and R2 and streams them out as bytes over a valid/ready handshake, followed by an XOR checksum byte. It sits beside the datapath and the controller, taps the register outputs, and feeds a byte-wide debug/host link.

## Interface
- W, 32, register width; fixed at 32, 4 bytes per register
- NBYTES, 13, frame length: 12 data bytes + 1 checksum byte (derived, not overridable)

- clk  in  1  clock, rising-edge
- res  in  1  reset, asynchronous, active-low
- start  in  1  transfer request, sampled in IDLE only
- r0in  in  32  R0 contents
- r1in  in  32  R1 contents
- r2in  in  32  R2 contents
- dout  out  8  current frame byte
- dvalid  out  1  dout holds a valid byte
- dready  in  1  sink accepts byte when dvalid && dready at a rising edge
- idx  out  4  index of byte on dout, 0..12
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the checksum byte is accepted

## Operation
- States: IDLE, SEND, DONE.
- IDLE: dvalid=0, busy=0. On an edge with start=1, capture {r2in, r1in, r0in} into a 96-bit shift register, clear the checksum accumulator and byte counter, and go to SEND.
- SEND: dvalid=1. For counter 0..11, dout = shift register [7:0]. For counter 12, dout = checksum.
- On each accepted byte (dvalid && dready):
  - shift right by 8;
  - checksum ^= dout (data bytes only);
  - counter++.
- After byte 12 is accepted, go to DONE.
- Byte order: r0 byte0 (LSB) first, up to r2 byte3. The checksum is the XOR of the 12 data bytes.
- DONE: dvalid=0, done=1, busy=1 for exactly one cycle, then IDLE.
- idx = counter in SEND. idx = 0 in IDLE and DONE.
- start is ignored in SEND and DONE; it is not queued. Register inputs changing after the snapshot do not affect the frame.
- All outputs are registered or decoded from registered state only. There is no combinational path from dready or start to any output.

## Timing
- Reset (res=0, async): state IDLE, shift register 0, checksum 0, counter 0; dout=0, dvalid=0, idx=0, busy=0, done=0. Applies immediately, including mid-frame. The partial frame is abandoned; no done pulse.
- First byte: start sampled high at edge k gives dvalid=1 and idx=0 after edge k.
- With dready held high: one byte per cycle. The last byte is accepted at edge k+13, done is high in the cycle after edge k+13, and IDLE follows after edge k+14.
- Backpressure: while dvalid && !dready, dout and idx hold stable and the counter does not advance. Stalls of any length are legal.
- A new start is accepted no earlier than the edge after done (first IDLE edge). Minimum frame-to-frame period is 15 cycles.
- dready while dvalid=0 has no effect.

## Test plan
- Basic frame: r0=32'h04030201, r1=32'h08070605, r2=32'h0C0B0A09, start pulse, dready=1.
  - Required: dout 01,02,...,0C then 0D? No: checksum 0C, so 13 bytes are 01..0C followed by 0C.
  - idx 0..12 in consecutive cycles; done one cycle; busy low afterwards.
- Backpressure: same data; dready toggles 1,0,0,1,... → dout/idx hold during low cycles; byte sequence identical; done follows the 13th acceptance.
- Snapshot isolation: start with r0=32'hDEADBEEF, r1=0, r2=0; change r0 to 32'h0 the next cycle → bytes EF,BE,AD,DE then 8×00; checksum 0x22.
- Start ignored while busy: pulse start at idx=5 and during DONE → exactly one frame of 13 bytes, one done pulse, busy low after DONE.
- Reset mid-frame: assert res=0 at idx=7 → dvalid, busy, idx drop to 0 immediately, no done. A subsequent start sends a full correct 13-byte frame starting at idx 0.
- Back-to-back: start held high continuously, dready=1 → frames start 15 cycles apart, each with a correct checksum.
